// File: rtl/mult_div_unit.sv
// Iterative MIPS HI/LO multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with sign fix-up and MTHI/MTLO writes.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CW-1:0]     r_cnt;
   logic [W2-1:0]     r_acc;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_is_div;
   logic              r_neg_res;
   logic              r_neg_a;
   logic              r_dz;
   logic              r_busy;
   logic              r_done;
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_lo;

   logic              w_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [WIDTH-1:0]  w_a_abs;
   logic [WIDTH-1:0]  w_b_abs;
   logic [WIDTH:0]    w_mul_sum;
   logic [W2-1:0]     w_mul_next;
   logic [WIDTH:0]    w_div_cand;
   logic [WIDTH:0]    w_div_diff;
   logic              w_div_ok;
   logic [W2-1:0]     w_div_next;
   logic [W2-1:0]     w_prod;
   logic [WIDTH-1:0]  w_quo;
   logic [WIDTH-1:0]  w_rem;
   logic [WIDTH-1:0]  w_a_orig;

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

   // Operand conditioning: op[0]=0 selects the signed variants
   assign w_signed = ~op[0];
   assign w_a_neg  = w_signed & a[WIDTH-1];
   assign w_b_neg  = w_signed & b[WIDTH-1];
   assign w_a_abs  = w_a_neg ? WIDTH'(-a) : a;
   assign w_b_abs  = w_b_neg ? WIDTH'(-b) : b;

   // Multiply step: accumulator upper half adds r_a when the multiplier LSB is set
   assign w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide step: remainder in upper half, dividend/quotient bits in lower half
   assign w_div_cand = r_acc[W2-1:WIDTH-1];
   assign w_div_diff = w_div_cand - {1'b0, r_b};
   assign w_div_ok   = ~w_div_diff[WIDTH];
   assign w_div_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_cand[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_div_ok};

   assign w_prod   = r_neg_res ? W2'(-r_acc) : r_acc;
   assign w_quo    = r_neg_res ? WIDTH'(-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
   assign w_rem    = r_neg_a ? WIDTH'(-r_acc[W2-1:WIDTH]) : r_acc[W2-1:WIDTH];
   assign w_a_orig = r_neg_a ? WIDTH'(-r_a) : r_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_RUN;
         S_RUN:   if (r_cnt == CW'(1)) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_is_div  <= 1'b0;
         r_neg_res <= 1'b0;
         r_neg_a   <= 1'b0;
         r_dz      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mthi) r_hi <= wdata;
               if (mtlo) r_lo <= wdata;
               if (start) begin
                  r_a       <= w_a_abs;
                  r_b       <= w_b_abs;
                  r_is_div  <= op[1];
                  r_neg_res <= w_a_neg ^ w_b_neg;
                  r_neg_a   <= w_a_neg;
                  r_dz      <= op[1] & (b == '0);
                  r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_a_abs : w_b_abs)};
                  r_cnt     <= CW'(WIDTH);
                  r_busy    <= 1'b1;
               end
            end
            S_RUN: begin
               r_acc <= r_is_div ? w_div_next : w_mul_next;
               r_cnt <= r_cnt - CW'(1);
            end
            S_FIX: begin
               if (!r_is_div) begin
                  r_hi <= w_prod[W2-1:WIDTH];
                  r_lo <= w_prod[WIDTH-1:0];
               end else if (r_dz) begin
                  r_hi <= w_a_orig;
                  r_lo <= '1;
               end else begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO pushed on issue, a
// monitor pops and compares on every done pulse.
module tb_mult_div_unit;

   localparam int unsigned W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          mthi;
   logic          mtlo;
   logic [W-1:0]  wdata;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   logic [2*W-1:0] sb_q[$];
   int n_cmp = 0;
   int n_err = 0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            logic [2*W-1:0] e;
            e = sb_q.pop_front();
            chk("result_hi", 64'(hi), 64'(e[2*W-1:W]));
            chk("result_lo", 64'(lo), 64'(e[W-1:0]));
         end
      end
   end

   // Called at a negedge; returns at the negedge showing done.
   // mode 1: mid-run MTLO + second start; mode 2: MTHI together with start.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input int mode, input logic [W-1:0] hold);
      int  cyc;
      int  busy_n;
      logic got;
      start = 1'b1; op = o; a = ia; b = ib;
      if (mode == 2) begin mthi = 1'b1; wdata = 32'hA5A5A5A5; end
      sb_q.push_back({ehi, elo});
      cyc = 0; busy_n = 0; got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            start = 1'b0; mthi = 1'b0;
            if (mode == 2) chk("mthi_with_start", 64'(hi), 64'(32'hA5A5A5A5));
         end
         if (mode == 1 && cyc == 5) begin
            mtlo = 1'b1; wdata = 32'hDEADBEEF;
            start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
         end
         if (mode == 1 && cyc == 6) begin mtlo = 1'b0; start = 1'b0; end
         if (mode == 1 && cyc == 7) chk("mtlo_while_busy", 64'(lo), 64'(hold));
         if (done) begin got = 1'b1; break; end
         if (busy) busy_n++;
      end
      chk("done_seen", 64'(got), 64'(1));
      chk("busy_cycles", 64'(busy_n), 64'(33));
      chk("busy_in_done", 64'(busy), 64'(0));
   endtask

   initial begin
      int dn;
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, '0);
      @(negedge clk);
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, '0);
      run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, '0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, '0);
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, '0);
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, '0);
      run_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 0, '0);
      run_op(2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, '0);
      run_op(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'h6, 2, '0);

      // MTHI/MTLO in IDLE
      @(negedge clk);
      mthi = 1'b1; wdata = 32'h12345678;
      @(negedge clk);
      mthi = 1'b0;
      chk("mthi_idle_hi", 64'(hi), 64'(32'h12345678));
      chk("mthi_idle_lo", 64'(lo), 64'(32'h6));
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BADF00D;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      chk("mthi_both_hi", 64'(hi), 64'(32'h0BADF00D));
      chk("mtlo_both_lo", 64'(lo), 64'(32'h0BADF00D));

      run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1, 32'h0BADF00D);

      // Abort a MULT mid-run with reset
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'hFFFFFFFD;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_hi", 64'(hi), 64'(0));
      chk("abort_lo", 64'(lo), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'(0));

      run_op(2'b01, 32'h00010000, 32'h00010000, 32'd1, 32'd0, 0, '0);
      @(negedge clk);
      chk("hold_after_done_hi", 64'(hi), 64'(1));
      chk("sb_empty", 64'(sb_q.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
